ex_stage_div: RTL and testbench

- Next-generation execute stage of the 5-stage in-order CPU; sits between ID and MEM.
- Owns its own ID→EX pipeline register with a valid/allow_in handshake, so EX can stall.
- Adds an iterative integer divider: signed/unsigned, quotient/remainder, multi-cycle, with stall and flush.
- Issues the data-RAM request exactly once per memory instruction, in the cycle the instruction hands off to MEM.

---
 rtl/ex_stage_div_pkg.sv | 31 +++
 rtl/ex_stage_div_alu.sv | 39 +++
 rtl/ex_stage_div_div_iter.sv | 132 +++++++++++++
 rtl/ex_stage_div.sv | 135 +++++++++++++
 tb/tb_ex_stage_div.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_div_pkg.sv
// Shared definitions for the execute stage with iterative divider.
//   div_state_e : divider FSM encodings (IDLE/BUSY/DONE)
//   DIV_*_BIT   : bit positions inside the 3-bit div_op field
//   ALU_*       : bit positions inside the one-hot ALU opcode
package ex_stage_div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam int unsigned DIV_OP_W       = 3;
   localparam int unsigned DIV_EN_BIT     = 2;
   localparam int unsigned DIV_SIGNED_BIT = 1;
   localparam int unsigned DIV_REM_BIT    = 0;

   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_SLT  = 2;
   localparam int unsigned ALU_SLTU = 3;
   localparam int unsigned ALU_AND  = 4;
   localparam int unsigned ALU_NOR  = 5;
   localparam int unsigned ALU_OR   = 6;
   localparam int unsigned ALU_XOR  = 7;
   localparam int unsigned ALU_SLL  = 8;
   localparam int unsigned ALU_SRL  = 9;
   localparam int unsigned ALU_SRA  = 10;
   localparam int unsigned ALU_LUI  = 11;

endpackage

// File: rtl/ex_stage_div_alu.sv
// Combinational integer ALU with one-hot opcode.
//   alu_op     : one-hot operation select (ALU_* bit positions)
//   alu_src1/2 : operands
//   alu_result : selected result (zero when no op bit is set)
module ex_stage_div_alu
   import ex_stage_div_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 12
) (
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [XLEN-1:0]     alu_src1,
   input  logic [XLEN-1:0]     alu_src2,
   output logic [XLEN-1:0]     alu_result
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);

   logic [SHAMT_W-1:0] shamt;
   assign shamt = alu_src2[SHAMT_W-1:0];

   // One-hot opcode, so the selected terms are simply OR-ed together
   always_comb begin
      alu_result = '0;
      if (alu_op[ALU_ADD])  alu_result |= alu_src1 + alu_src2;
      if (alu_op[ALU_SUB])  alu_result |= alu_src1 - alu_src2;
      if (alu_op[ALU_SLT])  alu_result |= XLEN'($signed(alu_src1) < $signed(alu_src2));
      if (alu_op[ALU_SLTU]) alu_result |= XLEN'(alu_src1 < alu_src2);
      if (alu_op[ALU_AND])  alu_result |= alu_src1 & alu_src2;
      if (alu_op[ALU_NOR])  alu_result |= ~(alu_src1 | alu_src2);
      if (alu_op[ALU_OR])   alu_result |= alu_src1 | alu_src2;
      if (alu_op[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
      if (alu_op[ALU_SLL])  alu_result |= alu_src1 << shamt;
      if (alu_op[ALU_SRL])  alu_result |= alu_src1 >> shamt;
      if (alu_op[ALU_SRA])  alu_result |= XLEN'($signed(alu_src1) >>> shamt);
      if (alu_op[ALU_LUI])  alu_result |= alu_src2;
   end

endmodule

// File: rtl/ex_stage_div_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
//   start     : begin a divide (sampled in IDLE)
//   is_signed : treat a/b as two's complement
//   want_rem  : return remainder instead of quotient
//   a, b      : dividend, divisor
//   flush     : abandon any divide, back to IDLE
//   ack       : result consumed, DONE -> IDLE
//   done      : result valid (combinational, state==DONE)
//   result    : sign-corrected quotient or remainder
module ex_stage_div_div_iter
   import ex_stage_div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            is_signed,
   input  logic            want_rem,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   input  logic            ack,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   dsr_q, dsr_d;
   logic              neg_q_q, neg_q_d;
   logic              neg_r_q, neg_r_d;
   logic              dbz_q, dbz_d;
   logic              sel_rem_q, sel_rem_d;

   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     partial, trial;
   logic [XLEN-1:0]   q_fix, r_fix;

   // Magnitudes; -INT_MIN wraps to INT_MIN, which is the right unsigned magnitude
   assign a_abs = (is_signed && a[XLEN-1]) ? -a : a;
   assign b_abs = (is_signed && b[XLEN-1]) ? -b : b;

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dsr_d     = dsr_q;
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      dbz_d     = dbz_q;
      sel_rem_d = sel_rem_q;

      partial = {rem_q, quo_q[XLEN-1]};
      trial   = partial - {1'b0, dsr_q};

      unique case (state_q)
         DIV_IDLE: begin
            if (start) begin
               state_d   = DIV_BUSY;
               cnt_d     = CNT_W'(XLEN);
               rem_d     = '0;
               quo_d     = a_abs;
               dsr_d     = b_abs;
               neg_q_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
               neg_r_d   = is_signed & a[XLEN-1];
               dbz_d     = (b == '0);
               sel_rem_d = want_rem;
            end
         end
         DIV_BUSY: begin
            // Dividend bits shift out of quo while quotient bits shift in
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = partial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (ack) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase

      if (flush) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         dbz_q     <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dsr_q     <= dsr_d;
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
         dbz_q     <= dbz_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   // Sign fix; divide-by-zero forces an all-ones quotient, remainder is already the dividend
   assign q_fix  = dbz_q ? '1 : (neg_q_q ? -quo_q : quo_q);
   assign r_fix  = neg_r_q ? -rem_q : rem_q;
   assign result = sel_rem_q ? r_fix : q_fix;
   assign done   = (state_q == DIV_DONE);

endmodule

// File: rtl/ex_stage_div.sv
// Execute stage: ID->EX pipeline register, ALU, iterative divider, data-RAM request.
//   ID_valid/EX_allow_in   : handshake with ID
//   flush                  : squash EX contents (highest priority)
//   alu_op..pc             : instruction payload from ID
//   MEM_allow_in           : MEM accepts this cycle
//   EX_ready_go            : EX result is final
//   EXreg_valid            : valid toward MEM
//   data_sram_en/addr      : data-RAM request, issued once at hand-off
//   EXreg_2MEM             : {ex_result, rkd_value, mem_we}
//   EXreg_2WB              : {rf_we, res_from_mem, rf_waddr, pc}
module ex_stage_div
   import ex_stage_div_pkg::*;
#(
   parameter  int unsigned XLEN       = 32,
   parameter  int unsigned ALU_OP_W   = 12,
   parameter  int unsigned RF_ADDR_W  = 5,
   localparam int unsigned EX2MEM_LEN = 2*XLEN + XLEN/8,
   localparam int unsigned EX2WB_LEN  = 2 + RF_ADDR_W + XLEN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ID_valid,
   output logic                  EX_allow_in,
   input  logic                  flush,
   input  logic [ALU_OP_W-1:0]   alu_op,
   input  logic [XLEN-1:0]       alu_src1,
   input  logic [XLEN-1:0]       alu_src2,
   input  logic [DIV_OP_W-1:0]   div_op,
   input  logic                  mem_en,
   input  logic [XLEN/8-1:0]     mem_we,
   input  logic [XLEN-1:0]       rkd_value,
   input  logic                  rf_we,
   input  logic                  res_from_mem,
   input  logic [RF_ADDR_W-1:0]  rf_waddr,
   input  logic [XLEN-1:0]       pc,
   input  logic                  MEM_allow_in,
   output logic                  EX_ready_go,
   output logic                  EXreg_valid,
   output logic                  data_sram_en,
   output logic [XLEN-1:0]       data_sram_addr,
   output logic [EX2MEM_LEN-1:0] EXreg_2MEM,
   output logic [EX2WB_LEN-1:0]  EXreg_2WB
);

   logic                 ex_valid;
   logic [ALU_OP_W-1:0]  alu_op_q;
   logic [XLEN-1:0]      src1_q, src2_q;
   logic [DIV_OP_W-1:0]  div_op_q;
   logic                 mem_en_q;
   logic [XLEN/8-1:0]    mem_we_q;
   logic [XLEN-1:0]      rkd_q;
   logic                 rf_we_q, res_from_mem_q;
   logic [RF_ADDR_W-1:0] rf_waddr_q;
   logic [XLEN-1:0]      pc_q;

   logic [XLEN-1:0]      alu_result, div_result, ex_result;
   logic                 div_done, div_en;

   // ID->EX pipeline register; flush beats a simultaneous load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid       <= 1'b0;
         alu_op_q       <= '0;
         src1_q         <= '0;
         src2_q         <= '0;
         div_op_q       <= '0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= '0;
         rkd_q          <= '0;
         rf_we_q        <= 1'b0;
         res_from_mem_q <= 1'b0;
         rf_waddr_q     <= '0;
         pc_q           <= '0;
      end else begin
         if (flush)            ex_valid <= 1'b0;
         else if (EX_allow_in) ex_valid <= ID_valid;

         if (ID_valid && EX_allow_in && !flush) begin
            alu_op_q       <= alu_op;
            src1_q         <= alu_src1;
            src2_q         <= alu_src2;
            div_op_q       <= div_op;
            mem_en_q       <= mem_en;
            mem_we_q       <= mem_we;
            rkd_q          <= rkd_value;
            rf_we_q        <= rf_we;
            res_from_mem_q <= res_from_mem;
            rf_waddr_q     <= rf_waddr;
            pc_q           <= pc;
         end
      end
   end

   ex_stage_div_alu #(
      .XLEN     (XLEN),
      .ALU_OP_W (ALU_OP_W)
   ) u_alu (
      .alu_op     (alu_op_q),
      .alu_src1   (src1_q),
      .alu_src2   (src2_q),
      .alu_result (alu_result)
   );

   assign div_en = div_op_q[DIV_EN_BIT];

   // Hand-off (MEM_allow_in while DONE) returns the divider to IDLE
   ex_stage_div_div_iter #(
      .XLEN (XLEN)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (ex_valid & div_en),
      .is_signed (div_op_q[DIV_SIGNED_BIT]),
      .want_rem  (div_op_q[DIV_REM_BIT]),
      .a         (src1_q),
      .b         (src2_q),
      .flush     (flush),
      .ack       (MEM_allow_in),
      .done      (div_done),
      .result    (div_result)
   );

   assign ex_result   = div_en ? div_result : alu_result;
   assign EX_ready_go = !div_en | div_done;
   assign EX_allow_in = !ex_valid | (EX_ready_go & MEM_allow_in);
   assign EXreg_valid = ex_valid & EX_ready_go;

   // Only raised in the hand-off cycle, so a stalled store is requested once
   assign data_sram_en   = ex_valid & mem_en_q & EX_ready_go & MEM_allow_in;
   assign data_sram_addr = alu_result;

   assign EXreg_2MEM = {ex_result, rkd_q, mem_we_q};
   assign EXreg_2WB  = {rf_we_q, res_from_mem_q, rf_waddr_q, pc_q};

endmodule

// File: tb/tb_ex_stage_div.sv
module tb_ex_stage_div;

   localparam int unsigned XLEN = 32;
   localparam int unsigned LAT  = XLEN + 1;

   localparam logic [11:0] OP_ADD  = 12'h001;
   localparam logic [11:0] OP_SUB  = 12'h002;
   localparam logic [11:0] OP_SLT  = 12'h004;
   localparam logic [11:0] OP_SLTU = 12'h008;
   localparam logic [11:0] OP_AND  = 12'h010;
   localparam logic [11:0] OP_NOR  = 12'h020;
   localparam logic [11:0] OP_OR   = 12'h040;
   localparam logic [11:0] OP_XOR  = 12'h080;
   localparam logic [11:0] OP_SLL  = 12'h100;
   localparam logic [11:0] OP_SRL  = 12'h200;
   localparam logic [11:0] OP_SRA  = 12'h400;
   localparam logic [11:0] OP_LUI  = 12'h800;

   logic        clk = 1'b0;
   logic        reset;
   logic        ID_valid, EX_allow_in, flush;
   logic [11:0] alu_op;
   logic [31:0] alu_src1, alu_src2;
   logic [2:0]  div_op;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] rkd_value;
   logic        rf_we, res_from_mem;
   logic [4:0]  rf_waddr;
   logic [31:0] pc;
   logic        MEM_allow_in, EX_ready_go, EXreg_valid, data_sram_en;
   logic [31:0] data_sram_addr;
   logic [67:0] EXreg_2MEM;
   logic [38:0] EXreg_2WB;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] rkd;
      logic [3:0]  we;
      logic        me;
      logic [38:0] wb;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          sram_pulses = 0;
   logic [31:0] pc_ctr = 32'h1000;
   logic [31:0] rkd_v  = 32'h0;
   logic [3:0]  we_v   = 4'h0;

   ex_stage_div #(.XLEN(32), .ALU_OP_W(12), .RF_ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .ID_valid(ID_valid), .EX_allow_in(EX_allow_in),
      .flush(flush), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .div_op(div_op), .mem_en(mem_en), .mem_we(mem_we), .rkd_value(rkd_value),
      .rf_we(rf_we), .res_from_mem(res_from_mem), .rf_waddr(rf_waddr), .pc(pc),
      .MEM_allow_in(MEM_allow_in), .EX_ready_go(EX_ready_go), .EXreg_valid(EXreg_valid),
      .data_sram_en(data_sram_en), .data_sram_addr(data_sram_addr),
      .EXreg_2MEM(EXreg_2MEM), .EXreg_2WB(EXreg_2WB)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: compare at every hand-off to MEM
   always @(negedge clk) begin
      if (reset) begin
         if (data_sram_en) sram_pulses++;
         if (EXreg_valid && !MEM_allow_in) check_eq("stall_no_req", data_sram_en, 1'b0);
         if (EXreg_valid && MEM_allow_in) begin
            check_eq("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check_eq("ex_result", EXreg_2MEM[67:36], e.res);
               check_eq("ex2mem", EXreg_2MEM, {e.res, e.rkd, e.we});
               check_eq("ex2wb", EXreg_2WB, e.wb);
               check_eq("sram_en", data_sram_en, e.me);
               if (e.me) check_eq("sram_addr", data_sram_addr, e.res);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction and hold it until EX accepts it
   task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [2:0] dop, input logic me, input logic [31:0] exp_res,
                        output int waits);
      logic acc;
      exp_t e;
      alu_op = op; alu_src1 = s1; alu_src2 = s2; div_op = dop;
      mem_en = me; mem_we = we_v; rkd_value = rkd_v;
      rf_we = 1'b1; res_from_mem = me; rf_waddr = 5'(pc_ctr >> 2); pc = pc_ctr;
      ID_valid = 1'b1;
      waits = 0;
      acc = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = EX_allow_in;
         @(posedge clk);
         #1;
         if (acc) break;
         waits++;
      end
      if (acc) begin
         e.res = exp_res; e.rkd = rkd_v; e.we = we_v; e.me = me;
         e.wb  = {1'b1, me, 5'(pc_ctr >> 2), pc_ctr};
         sb.push_back(e);
      end else begin
         check_eq("issue_timeout", acc, 1'b1);
      end
      ID_valid = 1'b0;
      pc_ctr   = pc_ctr + 32'd4;
   endtask

   // Count cycles with EX_ready_go low after a divide enters EX
   task automatic div_latency();
      int lat = 0;
      int bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (EX_ready_go) break;
         if (EX_allow_in) bad++;
         lat++;
      end
      check_eq("div_latency", lat, LAT);
      check_eq("div_allow_in_low", bad, 0);
   endtask

   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] dop,
                         input logic [31:0] exp_res);
      int w;
      tick();
      issue(12'h0, a, b, dop, 1'b0, exp_res, w);
      check_eq("div_accept", w, 0);
      div_latency();
   endtask

   task automatic alu_op_chk(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                             input logic [31:0] exp_res);
      int w;
      issue(op, s1, s2, 3'b000, 1'b0, exp_res, w);
      check_eq("alu_b2b_wait", w, 0);
   endtask

   logic [31:0] ua, ub;
   int          sa, sbv, w;
   int          pulses0;

   initial begin
      reset = 1'b0; ID_valid = 1'b0; flush = 1'b0; alu_op = '0; alu_src1 = '0;
      alu_src2 = '0; div_op = '0; mem_en = 1'b0; mem_we = '0; rkd_value = '0;
      rf_we = 1'b0; res_from_mem = 1'b0; rf_waddr = '0; pc = '0; MEM_allow_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", EXreg_valid, 1'b0);
      check_eq("rst_allow_in", EX_allow_in, 1'b1);
      check_eq("rst_sram_en", data_sram_en, 1'b0);
      check_eq("rst_ready_go", EX_ready_go, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_valid", EXreg_valid, 1'b0);
      check_eq("post_rst_allow_in", EX_allow_in, 1'b1);
      check_eq("post_rst_sram_en", data_sram_en, 1'b0);

      // Single ADD, visible one cycle after acceptance
      tick();
      issue(OP_ADD, 32'd5, 32'd7, 3'b000, 1'b0, 32'd12, w);
      check_eq("add_wait", w, 0);
      @(negedge clk);
      check_eq("add_valid", EXreg_valid, 1'b1);

      // Back-to-back ALU stream, one per cycle
      tick();
      alu_op_chk(OP_SUB,  32'd3,        32'd5,        32'hFFFF_FFFE);
      alu_op_chk(OP_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1);
      alu_op_chk(OP_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0);
      alu_op_chk(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      alu_op_chk(OP_NOR,  32'd0,        32'd0,        32'hFFFF_FFFF);
      alu_op_chk(OP_OR,   32'd1,        32'd2,        32'd3);
      alu_op_chk(OP_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0);
      alu_op_chk(OP_SLL,  32'd1,        32'd4,        32'd16);
      alu_op_chk(OP_SRL,  32'h8000_0000, 32'd31,      32'd1);
      alu_op_chk(OP_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000);
      alu_op_chk(OP_LUI,  32'd0,        32'h1234_5000, 32'h1234_5000);

      // Signed, remainder, divide-by-zero and overflow corners
      do_div(32'hFFFF_FFF9, 32'd2, 3'b110, 32'hFFFF_FFFD);
      do_div(32'hFFFF_FFF9, 32'd2, 3'b111, 32'hFFFF_FFFF);
      do_div(32'd9, 32'd0, 3'b100, 32'hFFFF_FFFF);
      do_div(32'd9, 32'd0, 3'b101, 32'd9);
      do_div(32'hFFFF_FFF7, 32'd0, 3'b110, 32'hFFFF_FFFF);
      do_div(32'hFFFF_FFF7, 32'd0, 3'b111, 32'hFFFF_FFF7);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h8000_0000);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000);

      // Back-to-back divides: the second waits for hand-off, then full latency
      tick();
      issue(12'h0, 32'd1000, 32'd10, 3'b100, 1'b0, 32'd100, w);
      issue(12'h0, 32'd1000, 32'd7, 3'b101, 1'b0, 32'd6, w);
      check_eq("b2b_div_wait", w, LAT);
      div_latency();

      // Random divides against the language's own operators
      for (int i = 0; i < 3; i++) begin
         ua = $urandom;
         ub = 32'($urandom_range(1, 5000));
         if (i % 2 == 1) do_div(ua, ub, 3'b101, ua % ub);
         else            do_div(ua, ub, 3'b100, ua / ub);
      end
      for (int i = 0; i < 4; i++) begin
         sa  = int'($urandom);
         sbv = int'($urandom_range(2, 3000));
         if (i < 2) sbv = -sbv;
         if (i % 2 == 1) do_div(32'(sa), 32'(sbv), 3'b111, 32'(sa % sbv));
         else            do_div(32'(sa), 32'(sbv), 3'b110, 32'(sa / sbv));
      end

      // Store stalled by MEM for 3 cycles: one request only
      tick();
      MEM_allow_in = 1'b0;
      rkd_v = 32'hDEAD_BEEF; we_v = 4'hF;
      pulses0 = sram_pulses;
      issue(OP_ADD, 32'h0000_00F0, 32'h0000_0010, 3'b000, 1'b1, 32'h0000_0100, w);
      rkd_v = 32'h0; we_v = 4'h0;
      repeat (3) begin
         @(negedge clk);
         check_eq("store_stall_en", data_sram_en, 1'b0);
         check_eq("store_stall_valid", EXreg_valid, 1'b1);
      end
      tick();
      MEM_allow_in = 1'b1;
      repeat (3) tick();
      check_eq("store_pulses", sram_pulses - pulses0, 1);

      // Flush during BUSY, with a colliding ID_valid that must not load
      tick();
      issue(12'h0, 32'd55, 32'd5, 3'b100, 1'b0, 32'd11, w);
      repeat (10) tick();
      flush = 1'b1;
      ID_valid = 1'b1; alu_op = OP_ADD; alu_src1 = 32'd1; alu_src2 = 32'd1;
      div_op = 3'b000; mem_en = 1'b0;
      tick();
      flush = 1'b0;
      ID_valid = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      check_eq("flush_valid", EXreg_valid, 1'b0);
      check_eq("flush_allow_in", EX_allow_in, 1'b1);
      check_eq("flush_sram_en", data_sram_en, 1'b0);
      do_div(32'd100, 32'd7, 3'b100, 32'd14);

      // Reset in the middle of a divide
      tick();
      issue(12'h0, 32'd77, 32'd3, 3'b100, 1'b0, 32'd25, w);
      repeat (5) tick();
      reset = 1'b0;
      #1;
      check_eq("midrst_valid", EXreg_valid, 1'b0);
      check_eq("midrst_allow_in", EX_allow_in, 1'b1);
      check_eq("midrst_ready_go", EX_ready_go, 1'b1);
      check_eq("midrst_sram_en", data_sram_en, 1'b0);
      sb.delete();
      tick();
      reset = 1'b1;
      do_div(32'd77, 32'd3, 3'b101, 32'd2);
      tick();
      issue(OP_ADD, 32'd40, 32'd2, 3'b000, 1'b0, 32'd42, w);
      check_eq("post_midrst_wait", w, 0);

      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check_eq("sb_drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
